booth_mul_seq: RTL and testbench
================================

// Module: booth_mul_seq
// PURPOSE
//  Parametrised sequential radix-2 Booth multiplier with a start/busy/done handshake.
//  Generalises the fixed 8-bit keypad-calculator multiplier to any operand width.
//  Adds run-time signed/unsigned selection and a registered result with a sticky valid.
//  Sits between number_storage (operands) and bin_to_bcd/display path (result).
// PARAMETERS
//  WIDTH  8  operand width in bits; legal range >= 2; result is 2*WIDTH bits
// PORTS
//  clk          in   1        system clock, all logic rising-edge
//  rst          in   1        synchronous reset, active-high
//  start        in   1        request; sampled only in IDLE
//  signed_mode  in   1        1: A,B two's complement; 0: unsigned; sampled with start
//  A            in   WIDTH    multiplicand, sampled with start
//  B            in   WIDTH    multiplier, sampled with start
//  busy         out  1        high while state is RUN
//  done         out  1        one-cycle pulse, result just written to Y
//  valid        out  1        level; Y holds a completed product
//  Y            out  2*WIDTH  product register
// BEHAVIOUR
//  - Reset (sync, active-high, any state): state=IDLE, busy=0, done=0, valid=0, Y=0, internals cleared.
//  - Operands are extended to WIDTH+1 bits: sign-extended if signed_mode=1, zero-extended if 0.
//    Internal accumulator 2*(WIDTH+1)+1 bits (P,Q,q-1). Y = low 2*WIDTH bits of final product.
//    The result always fits: signed range and unsigned range both representable in 2*WIDTH bits.
//  - FSM states: IDLE, RUN, DONE.
//    IDLE: on start=1 at edge k -> load operands, clear P, q-1=0, cnt=0, valid<=0, go RUN.
//    RUN: each edge does one Booth step on {q0,q-1}: 01 add M, 10 sub M, 00/11 none;
//         then arithmetic right shift of {P,Q,q-1}; cnt++.
//         After WIDTH+1 steps (edge k+WIDTH+1) -> Y<=product, valid<=1, go DONE.
//    DONE: done=1 for exactly this one cycle; unconditionally -> IDLE next edge.
//  - Latency: done high in the cycle after edge k+WIDTH+1; busy high WIDTH+1 cycles.
//  - Back-to-back: start accepted in the IDLE cycle right after DONE; min issue interval WIDTH+3 cycles.
//  - start in RUN or DONE: ignored, no queuing. A/B/signed_mode changes after edge k: no effect.
//  - Y and valid hold indefinitely in IDLE; Y changes only on entry to DONE or reset.
//  - valid drops on the edge a new start is accepted; Y keeps the old value until the new DONE.
//  - Step counter width $clog2(WIDTH+2); no wrap-around is reachable.
// CONFIGURATION
//  BOOTH_ABORT_EN defined: adds input port abort (1 bit, after start).
//    abort=1 in RUN -> next edge IDLE; no done pulse; valid stays 0; Y unchanged.
//    abort wins over the final-step transition to DONE; abort in IDLE/DONE is ignored.
//    If abort and rst are both high, rst wins.
//  BOOTH_ABORT_EN undefined: no abort port; every accepted start ends in DONE unless rst.
// TESTING
//  1. WIDTH=8, signed, A=-7 (8'hF9), B=3 -> done 9 cycles after start edge, Y=16'hFFEB, valid=1.
//  2. WIDTH=8, unsigned: A=200,B=3 -> Y=16'h0258; A=255,B=255 -> Y=16'hFE01.
//  3. WIDTH=8, signed, A=B=8'h80 -> Y=16'h4000; A=8'h80,B=8'h7F -> Y=16'hC080.
//  4. Pulse start again at cycle 3 of RUN with new A,B -> ignored; result of first op; one done pulse.
//  5. Assert rst in cycle 4 of RUN -> busy=0, done=0, valid=0, Y=0; next start runs cleanly.
//  6. WIDTH=4 instance, signed, A=-8, B=7 -> Y=8'hC8 after 5 cycles.
//     With BOOTH_ABORT_EN: abort in RUN -> no done; old Y retained; valid=0.

Source files
------------

// File: rtl/booth_mul_seq.sv
// booth_mul_seq
//   Sequential radix-2 Booth multiplier, one Booth step per clock, with a
//   start/busy/done handshake and a registered product with a sticky valid.
//   Operands are extended by one bit, which lets a single datapath serve
//   both signed and unsigned products.
//
// Parameters
//   WIDTH        operand width (>= 2); product is 2*WIDTH bits
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   start        request, sampled only in IDLE
//   abort        (BOOTH_ABORT_EN only) cancel a running multiply
//   signed_mode  1: two's complement operands, 0: unsigned; sampled with start
//   A, B         multiplicand / multiplier, sampled with start
//   busy         high while a multiply is running
//   done         one-cycle pulse when Y has just been written
//   valid        Y holds a completed product
//   Y            product register
//
// Optional feature macro: BOOTH_ABORT_EN (adds the abort input).

module booth_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
`ifdef BOOTH_ABORT_EN
    input  logic                 abort,
`endif
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic                 valid,
    output logic [2*WIDTH-1:0]   Y
);

    localparam int EW = WIDTH + 1;        // extended operand width
    localparam int AW = 2 * EW + 1;       // {P, Q, q-1}
    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [EW-1:0]   m;
    logic [AW-1:0]   acc;
    logic [AW-1:0]   step_acc;
    logic [CW-1:0]   cnt;
    logic [EW-1:0]   a_ext;
    logic [EW-1:0]   b_ext;
    logic [EW-1:0]   p_cur;
    logic [EW-1:0]   p_sum;
    logic            last_step;
    logic            abort_req;

`ifdef BOOTH_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Top extension bit is the sign in signed mode and zero otherwise.
    assign a_ext     = {signed_mode & A[WIDTH-1], A};
    assign b_ext     = {signed_mode & B[WIDTH-1], B};
    assign last_step = (cnt == CW'(WIDTH));

    // One Booth step followed by an arithmetic right shift of {P,Q,q-1}.
    always_comb begin
        p_cur = acc[AW-1 -: EW];
        case (acc[1:0])
            2'b01:   p_sum = p_cur + m;
            2'b10:   p_sum = p_cur - m;
            default: p_sum = p_cur;
        endcase
        step_acc = {p_sum[EW-1], p_sum, acc[EW:1]};
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (abort_req)      state_next = S_IDLE;
                else if (last_step) state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            m     <= '0;
            acc   <= '0;
            cnt   <= '0;
            Y     <= '0;
            valid <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        m     <= a_ext;
                        acc   <= {{EW{1'b0}}, b_ext, 1'b0};
                        cnt   <= '0;
                        valid <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (!abort_req) begin
                        acc <= step_acc;
                        cnt <= cnt + 1'b1;
                        // Final step: the product is taken straight from the
                        // step result so Y is ready when DONE is entered.
                        if (last_step) begin
                            Y     <= step_acc[2*WIDTH:1];
                            valid <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq
//   Self-checking bench for booth_mul_seq: WIDTH=8 and WIDTH=4 instances,
//   table-driven directed vectors, randomized operands against an
//   arithmetic reference, and hand-written handshake corner cases.

module tb_booth_mul_seq;

    logic        clk;
    logic        rst;
    logic        start8, sm8, busy8, done8, valid8;
    logic [7:0]  a8, b8;
    logic [15:0] y8;
    logic        start4, sm4, busy4, done4, valid4;
    logic [3:0]  a4, b4;
    logic [7:0]  y4;
`ifdef BOOTH_ABORT_EN
    logic        abort8;
    logic        abort4;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    booth_mul_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8),
`ifdef BOOTH_ABORT_EN
        .abort(abort8),
`endif
        .signed_mode(sm8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .valid(valid8), .Y(y8)
    );

    booth_mul_seq #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .start(start4),
`ifdef BOOTH_ABORT_EN
        .abort(abort4),
`endif
        .signed_mode(sm4), .A(a4), .B(b4),
        .busy(busy4), .done(done4), .valid(valid4), .Y(y4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference product: interpret operands per mode, multiply as integers,
    // keep the low 2*w bits.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input bit sm, input int w);
        longint sa, sb, p;
        sa = longint'(a);
        sb = longint'(b);
        if (sm && a[w-1]) sa = sa - (longint'(1) << w);
        if (sm && b[w-1]) sb = sb - (longint'(1) << w);
        p = sa * sb;
        return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // Issue one WIDTH=8 multiply and wait for done; checks accept behaviour,
    // latency, busy duration and the result.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit sm,
                        input logic [15:0] exp_y, input string name);
        int cyc;
        int nbusy;
        logic [15:0] old_y;
        if (done8) tick();                 // DONE -> IDLE edge
        old_y  = y8;
        a8     = a;
        b8     = b;
        sm8    = sm;
        start8 = 1'b1;
        tick();                            // accept edge
        start8 = 1'b0;
        a8     = ~a;                       // later operand changes must not matter
        b8     = ~b;
        sm8    = ~sm;
        chk({name, " valid drops on accept"}, 64'(valid8), 64'd0);
        chk({name, " Y held during run"}, 64'(y8), 64'(old_y));
        cyc   = 0;
        nbusy = 0;
        while (!done8 && cyc < 40) begin
            if (busy8) nbusy++;
            tick();
            cyc++;
        end
        chk({name, " latency"}, 64'(cyc), 64'd9);
        chk({name, " busy cycles"}, 64'(nbusy), 64'd9);
        chk({name, " Y"}, 64'(y8), 64'(exp_y));
        chk({name, " valid"}, 64'(valid8), 64'd1);
        chk({name, " busy at done"}, 64'(busy8), 64'd0);
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input bit sm,
                        input logic [7:0] exp_y, input string name);
        int cyc;
        if (done4) tick();
        a4     = a;
        b4     = b;
        sm4    = sm;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        cyc    = 0;
        while (!done4 && cyc < 40) begin
            tick();
            cyc++;
        end
        chk({name, " latency"}, 64'(cyc), 64'd5);
        chk({name, " Y"}, 64'(y4), 64'(exp_y));
        chk({name, " valid"}, 64'(valid4), 64'd1);
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        bit          sm;
        logic [15:0] y;
    } vec_t;

    initial begin
        vec_t vecs[$];
        int   ndone;
        logic [7:0]  ra, rb;
        logic [3:0]  qa, qb;
        bit          rs;
        logic [15:0] keep_y;

        vecs.push_back('{8'hF9, 8'h03, 1'b1, 16'hFFEB});
        vecs.push_back('{8'd200, 8'd3, 1'b0, 16'h0258});
        vecs.push_back('{8'hFF, 8'hFF, 1'b0, 16'hFE01});
        vecs.push_back('{8'h80, 8'h80, 1'b1, 16'h4000});
        vecs.push_back('{8'h80, 8'h7F, 1'b1, 16'hC080});
        vecs.push_back('{8'hFF, 8'hFF, 1'b1, 16'h0001});
        vecs.push_back('{8'h80, 8'h80, 1'b0, 16'h4000});
        vecs.push_back('{8'h00, 8'hA5, 1'b1, 16'h0000});
        vecs.push_back('{8'h7F, 8'h7F, 1'b1, 16'h3F01});

        rst    = 1'b1;
        start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
`ifdef BOOTH_ABORT_EN
        abort8 = 1'b0;
        abort4 = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        chk("reset busy", 64'(busy8), 64'd0);
        chk("reset done", 64'(done8), 64'd0);
        chk("reset valid", 64'(valid8), 64'd0);
        chk("reset Y", 64'(y8), 64'd0);

        // Directed table, issued back-to-back.
        foreach (vecs[i])
            run8(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].y, $sformatf("vec%0d", i));

        // Result and valid hold in IDLE.
        keep_y = y8;
        repeat (6) tick();
        chk("idle hold Y", 64'(y8), 64'(keep_y));
        chk("idle hold valid", 64'(valid8), 64'd1);

        // Randomized operands against the arithmetic reference.
        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom_range(0, 1));
            run8(ra, rb, rs, 16'(ref_mul(32'(ra), 32'(rb), rs, 8)), $sformatf("rnd%0d", i));
        end

        // Second start mid-run is ignored: one done, first result.
        tick();
        a8 = 8'd12; b8 = 8'd11; sm8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (2) tick();
        a8 = 8'd99; b8 = 8'd77; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            if (done8) begin
                ndone++;
                chk("ignored start Y", 64'(y8), 64'd132);
            end
            tick();
        end
        chk("ignored start done count", 64'(ndone), 64'd1);
        chk("ignored start idle", 64'(busy8), 64'd0);

        // Reset during RUN clears everything; the next op runs cleanly.
        a8 = 8'd5; b8 = 8'd6; sm8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid reset busy", 64'(busy8), 64'd0);
        chk("mid reset done", 64'(done8), 64'd0);
        chk("mid reset valid", 64'(valid8), 64'd0);
        chk("mid reset Y", 64'(y8), 64'd0);
        run8(8'hF0, 8'h10, 1'b1, 16'hFF00, "after reset");

`ifdef BOOTH_ABORT_EN
        // Abort in RUN: no done, valid low, old Y retained.
        keep_y = y8;
        tick();
        a8 = 8'd3; b8 = 8'd3; sm8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (3) tick();
        abort8 = 1'b1;
        tick();
        abort8 = 1'b0;
        chk("abort busy", 64'(busy8), 64'd0);
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            if (done8) ndone++;
            tick();
        end
        chk("abort no done", 64'(ndone), 64'd0);
        chk("abort valid", 64'(valid8), 64'd0);
        chk("abort Y kept", 64'(y8), 64'(keep_y));
        run8(8'd7, 8'd9, 1'b0, 16'd63, "after abort");
`endif

        // WIDTH=4 instance.
        run4(4'h8, 4'h7, 1'b1, 8'hC8, "w4 -8*7");
        run4(4'hF, 4'hF, 1'b0, 8'hE1, "w4 15*15");
        for (int i = 0; i < 10; i++) begin
            qa = 4'($urandom);
            qb = 4'($urandom);
            rs = 1'($urandom_range(0, 1));
            run4(qa, qb, rs, 8'(ref_mul(32'(qa), 32'(qb), rs, 4)), $sformatf("w4 rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
